// File: rtl/bcx_pkg.sv
// Shared definitions for the block assembly and storage path.
// Field offsets locate each 32-bit word of the packed {a..h,w1..w3} state.
package bcx_pkg;

  localparam int BLOCK_BITS = 352;
  localparam int WORD_BITS  = 32;

  typedef logic [BLOCK_BITS-1:0] block_t;

  localparam int OFF_A  = 320;
  localparam int OFF_B  = 288;
  localparam int OFF_C  = 256;
  localparam int OFF_D  = 224;
  localparam int OFF_E  = 192;
  localparam int OFF_F  = 160;
  localparam int OFF_G  = 128;
  localparam int OFF_H  = 96;
  localparam int OFF_W1 = 64;
  localparam int OFF_W2 = 32;
  localparam int OFF_W3 = 0;

endpackage

// File: rtl/block_loader_beat_packer.sv
// Assembly shift register and beat counter for block_loader.
// A count of BEATS means a full block is parked here waiting for the holding register.
module beat_packer
  import bcx_pkg::*;
#(
  parameter int IN_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write_valid_i,
  input  logic [IN_WIDTH-1:0] block_data_i,
  input  logic                free_i,
  output logic                write_ready_o,
  output logic                complete_next_o,
  output logic                stalled_o,
  output block_t              asm_o,
  output block_t              packed_o
);

  localparam int BEATS = BLOCK_BITS / IN_WIDTH;
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(BEATS - 1);
  localparam logic [CW-1:0] STALL_CNT = CW'(BEATS);

  block_t        asm_q, asm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc;

  assign write_ready_o   = !rst && (cnt_q != STALL_CNT);
  assign acc             = write_valid_i && write_ready_o;
  assign complete_next_o = acc && (cnt_q == LAST_CNT);
  assign stalled_o       = (cnt_q == STALL_CNT);
  assign packed_o        = {asm_q[BLOCK_BITS-IN_WIDTH-1:0], block_data_i};
  assign asm_o           = asm_q;

  // A completing beat with nowhere to go parks the block by moving the count to BEATS.
  always_comb begin
    asm_d = asm_q;
    cnt_d = cnt_q;
    if (acc) asm_d = packed_o;
    if ((complete_next_o || stalled_o) && free_i) cnt_d = '0;
    else if (complete_next_o)                     cnt_d = STALL_CNT;
    else if (acc)                                 cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q <= '0;
      cnt_q <= '0;
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/block_loader.sv
// Packs narrow host beats into 352-bit blocks and double-buffers them for block_storage.
// A pop and a refill of the holding register may happen on the same edge.
module block_loader
  import bcx_pkg::*;
#(
  parameter int IN_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_valid,
  output logic                  write_ready,
  input  logic [IN_WIDTH-1:0]   block_data,
  input  logic                  read,
  output logic                  full,
  output logic [BLOCK_BITS-1:0] out,
  output logic [15:0]           blocks_loaded
);

  if (BLOCK_BITS % IN_WIDTH != 0) begin : g_width_check
    $error("block_loader: IN_WIDTH must divide 352");
  end

  block_t      out_q, out_d;
  logic        full_q, full_d;
  logic [15:0] loaded_q, loaded_d;
  logic        free, xfer, complete_next, stalled;
  block_t      asm_blk, packed_blk;

  assign free = !full_q || read;
  assign xfer = (complete_next || stalled) && free;

  beat_packer #(.IN_WIDTH(IN_WIDTH)) u_packer (
    .clk             (clk),
    .rst             (rst),
    .write_valid_i   (write_valid),
    .block_data_i    (block_data),
    .free_i          (free),
    .write_ready_o   (write_ready),
    .complete_next_o (complete_next),
    .stalled_o       (stalled),
    .asm_o           (asm_blk),
    .packed_o        (packed_blk)
  );

  // The final beat bypasses the assembly register so the block lands one edge earlier.
  always_comb begin
    out_d    = out_q;
    full_d   = full_q;
    loaded_d = loaded_q;
    if (xfer) begin
      out_d    = complete_next ? packed_blk : asm_blk;
      full_d   = 1'b1;
      loaded_d = loaded_q + 16'd1;
    end else if (read && full_q) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      full_q   <= 1'b0;
      loaded_q <= '0;
    end else begin
      out_q    <= out_d;
      full_q   <= full_d;
      loaded_q <= loaded_d;
    end
  end

  assign out           = out_q;
  assign full          = full_q;
  assign blocks_loaded = loaded_q;

endmodule
